// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared definitions for the FIFO-draining UART transmitter:
//   uartState_e      - transmitter state encoding (3 bits)
//   READ_WAIT_CYCLES - cycles between the FIFO read strobe falling and the
//                      returned word being safe to capture
//   IDLE_LEVEL       - level of the serial line when nothing is being sent
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STROBE    = 3'd1,
        READ_WAIT = 3'd2,
        START     = 3'd3,
        DATA      = 3'd4,
        STOP      = 3'd5
    } uartState_e;

    localparam int   READ_WAIT_CYCLES = 3;
    localparam logic IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Free-running modulo-CLKS_PER_BIT counter used to time serial bits and the
// FIFO read wait. The owner clears it on every state entry so each state
// starts counting from zero.
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   clear_i    - synchronous clear, wins over counting
//   count_o    - current count value
//   bitDone_o  - high during the last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter  int CLKS_PER_BIT = 16,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o,
    output logic             bitDone_o
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Explicit wrap so non-power-of-two bit periods work.
    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || (count_q == LAST_COUNT)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign bitDone_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pops words from the circular-buffer FIFO with a one-cycle read strobe,
// captures the returned word and sends it as start bit, DBITS data bits
// (LSB first) and one stop bit. Drains the FIFO on its own while enabled.
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   enable     - while high, start a frame whenever the FIFO is non-empty
//   empty      - FIFO empty flag
//   fifo_dout  - FIFO read data
//   rd         - registered read strobe to the FIFO (FIFO pops on its fall)
//   tx         - registered serial line, idles high
//   busy       - high in every state except IDLE
//   word_count - number of completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DBITS        = 3,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             empty,
    input  logic [DBITS-1:0] fifo_dout,
    output logic             rd,
    output logic             tx,
    output logic             busy,
    output logic [7:0]       word_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DBITS > 1) ? $clog2(DBITS) : 1;

    uartState_e       state_q;
    uartState_e       state_d;
    logic [DBITS-1:0] shift_q;
    logic [DBITS-1:0] shift_d;
    logic [DBITS-1:0] shifted;
    logic [IDX_W-1:0] bitIdx_q;
    logic [IDX_W-1:0] bitIdx_d;
    logic             tx_q;
    logic             tx_d;
    logic             rd_q;
    logic             rd_d;
    logic [7:0]       wordCount_q;
    logic [7:0]       wordCount_d;

    logic             timerClear;
    logic [CNT_W-1:0] timerCount;
    logic             bitDone;
    logic             lastBit;

    // Restarting the timer on every state change lets READ_WAIT and each
    // serial bit count from zero without a second counter.
    assign timerClear = (state_d != state_q);
    assign lastBit    = (bitIdx_q == IDX_W'(DBITS - 1));
    assign shifted    = shift_q >> 1;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) bitTimer (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (timerClear),
        .count_o   (timerCount),
        .bitDone_o (bitDone)
    );

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitIdx_q    <= '0;
            tx_q        <= IDLE_LEVEL;
            rd_q        <= 1'b0;
            wordCount_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitIdx_q    <= bitIdx_d;
            tx_q        <= tx_d;
            rd_q        <= rd_d;
            wordCount_q <= wordCount_d;
        end
    end

    // Next-state logic. enable and empty only matter in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (enable && !empty) state_d = STROBE;
            STROBE:    state_d = READ_WAIT;
            READ_WAIT: if (timerCount == CNT_W'(READ_WAIT_CYCLES - 1)) state_d = START;
            START:     if (bitDone) state_d = DATA;
            DATA:      if (bitDone && lastBit) state_d = STOP;
            STOP:      if (bitDone) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath. The FIFO word is
    // only valid on the last READ_WAIT cycle, so it is captured there and
    // never looked at again for this frame.
    always_comb begin
        rd_d        = 1'b0;
        tx_d        = tx_q;
        shift_d     = shift_q;
        bitIdx_d    = bitIdx_q;
        wordCount_d = wordCount_q;
        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (state_d == STROBE) rd_d = 1'b1;
            end
            READ_WAIT: begin
                if (state_d == START) begin
                    shift_d  = fifo_dout;
                    bitIdx_d = '0;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (bitDone) tx_d = shift_q[0];
            end
            DATA: begin
                if (bitDone) begin
                    if (lastBit) begin
                        tx_d = IDLE_LEVEL;
                    end else begin
                        shift_d  = shifted;
                        bitIdx_d = bitIdx_q + 1'b1;
                        tx_d     = shifted[0];
                    end
                end
            end
            STOP: begin
                if (bitDone) wordCount_d = wordCount_q + 8'd1;
            end
            default: begin
            end
        endcase
    end

    assign rd         = rd_q;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign word_count = wordCount_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Self-checking bench for fifo_uart_tx with DBITS=3, CLKS_PER_BIT=4.
// A behavioural FIFO (array plus read/write pointers) answers the read
// strobe with the documented pop timing; expected serial frames come from
// the UART framing rule {stop, data, start} or from literal tables.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int DBITS       = 3;
    localparam int CPB         = 4;
    localparam int FRAME_SLOTS = DBITS + 2;

    logic             clock  = 1'b0;
    logic             reset  = 1'b1;
    logic             enable = 1'b0;
    logic             empty;
    logic [DBITS-1:0] fifo_dout = '0;
    logic             rd;
    logic             tx;
    logic             busy;
    logic [7:0]       word_count;

    int               vectors     = 0;
    int               miscompares = 0;
    logic [7:0]       expCount    = 8'd0;

    // Behavioural FIFO storage: the main thread owns wrPtr, the FIFO model
    // owns rdPtr and fifo_dout.
    logic [DBITS-1:0] wordMem [1024];
    logic [9:0]       wrPtr = 10'd0;
    logic [9:0]       rdPtr = 10'd0;
    logic             rdSeen = 1'b0;

    assign empty = (wrPtr == rdPtr);

    typedef struct {
        logic [DBITS-1:0]       word;
        logic                   pushSelf;
        int                     alsoQueue;
        logic [FRAME_SLOTS-1:0] slots;
        int                     dropSlot;
        logic [9:0]             expLeft;
    } vector_t;

    vector_t tbl [4];

    fifo_uart_tx #(
        .DBITS        (DBITS),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .empty      (empty),
        .fifo_dout  (fifo_dout),
        .rd         (rd),
        .tx         (tx),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    // FIFO read port: a falling rd pops the head, and data/empty change on
    // the second rising edge after the edge that dropped rd.
    always begin
        @(negedge clock);
        if (rdSeen && !rd) begin
            rdSeen = 1'b0;
            @(posedge clock);
            @(posedge clock);
            #1;
            if (rdPtr != wrPtr) begin
                fifo_dout = wordMem[rdPtr];
                rdPtr     = rdPtr + 10'd1;
            end
        end else begin
            rdSeen = rd;
        end
    end

    // Hang guard in case the DUT never responds at all.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // UART framing: start bit low, data LSB first, stop bit high.
    function automatic logic [FRAME_SLOTS-1:0] frameSlots(input logic [DBITS-1:0] word);
        return {1'b1, word, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %b, required %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0d, required %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [DBITS-1:0] word);
        wordMem[wrPtr] = word;
        wrPtr          = wrPtr + 10'd1;
    endtask

    // Waits (bounded) for the next strobe, then checks strobe width, the
    // 4-cycle strobe-to-start latency, every cycle of the frame, the idle
    // gap afterwards and the frame counter. Optionally drops enable at the
    // start of slot dropSlot.
    task automatic checkFrame(input logic [FRAME_SLOTS-1:0] expSlots, input int dropSlot);
        int waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (rd !== 1'b1 && waited < 100);
        if (rd !== 1'b1) begin
            checkOutput("rdTimeout", rd, 1'b1);
            return;
        end
        @(negedge clock);
        checkOutput("rdPulseWidth", rd, 1'b0);
        checkOutput("busyAfterStrobe", busy, 1'b1);
        repeat (2) begin
            @(negedge clock);
            checkOutput("txReadWait", tx, 1'b1);
        end
        for (int s = 0; s < FRAME_SLOTS; s++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                checkOutput($sformatf("txSlot%0d", s), tx, expSlots[s]);
                checkOutput("rdInFrame", rd, 1'b0);
                checkOutput("busyInFrame", busy, 1'b1);
                if (s == dropSlot && c == 0) enable = 1'b0;
            end
        end
        @(negedge clock);
        expCount = expCount + 8'd1;
        checkOutput("busyIdleGap", busy, 1'b0);
        checkCount("wordCount", 32'(word_count), 32'(expCount));
    endtask

    initial begin
        int               waited;
        int               burst;
        int               guard;
        logic [DBITS-1:0] w;
        logic [DBITS-1:0] burstQ [$];

        tbl[0] = '{3'b101, 1'b1, -1, 5'b11010, -1, 10'd0};
        tbl[1] = '{3'b011, 1'b1,  6, 5'b10110, -1, 10'd1};
        tbl[2] = '{3'b110, 1'b0, -1, 5'b11100, -1, 10'd0};
        tbl[3] = '{3'b111, 1'b1,  5, 5'b11110,  2, 10'd1};

        // Reset with an empty FIFO and enable already high.
        enable = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("resetRd", rd, 1'b0);
        checkOutput("resetTx", tx, 1'b1);
        checkOutput("resetBusy", busy, 1'b0);
        checkCount("resetCount", 32'(word_count), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            checkOutput("emptyIdleRd", rd, 1'b0);
            checkOutput("emptyIdleTx", tx, 1'b1);
            checkOutput("emptyIdleBusy", busy, 1'b0);
            checkCount("emptyIdleCount", 32'(word_count), 32'd0);
        end

        // Directed frames: single word, back-to-back pair, enable drop.
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].pushSelf) applyStimulus(tbl[i].word);
            if (tbl[i].alsoQueue >= 0) applyStimulus(DBITS'(tbl[i].alsoQueue));
            checkFrame(tbl[i].slots, tbl[i].dropSlot);
            checkCount("fifoLeft", 32'(wrPtr - rdPtr), 32'(tbl[i].expLeft));
        end

        // With enable low the queued word must stay put.
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            checkOutput("disabledRd", rd, 1'b0);
            checkOutput("disabledTx", tx, 1'b1);
            checkOutput("disabledBusy", busy, 1'b0);
        end
        checkCount("disabledFifoLeft", 32'(wrPtr - rdPtr), 32'd1);
        enable = 1'b1;
        checkFrame(frameSlots(3'b101), -1);
        checkCount("reenableFifoLeft", 32'(wrPtr - rdPtr), 32'd0);

        // Random bursts of words against the framing model.
        for (int k = 0; k < 12; k++) begin
            burst = $urandom_range(1, 3);
            for (int j = 0; j < burst; j++) begin
                w = DBITS'($urandom());
                burstQ.push_back(w);
                applyStimulus(w);
            end
            while (burstQ.size() > 0) begin
                w = burstQ.pop_front();
                checkFrame(frameSlots(w), -1);
            end
            repeat ($urandom_range(0, 4)) begin
                @(negedge clock);
                checkOutput("randomGapBusy", busy, 1'b0);
            end
        end
        checkCount("randomFifoLeft", 32'(wrPtr - rdPtr), 32'd0);

        // Asynchronous reset in the middle of a data bit that is low.
        applyStimulus(3'b101);
        applyStimulus(3'b100);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (rd !== 1'b1 && waited < 100);
        checkOutput("midResetStrobe", rd, 1'b1);
        repeat (4 + CPB + 1 + CPB) @(negedge clock);
        checkOutput("midResetTxBefore", tx, 1'b0);
        checkOutput("midResetBusyBefore", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncResetTx", tx, 1'b1);
        checkOutput("asyncResetRd", rd, 1'b0);
        checkOutput("asyncResetBusy", busy, 1'b0);
        checkCount("asyncResetCount", 32'(word_count), 32'd0);
        expCount = 8'd0;
        repeat (2) @(negedge clock);
        checkOutput("heldResetBusy", busy, 1'b0);
        reset = 1'b1;
        checkFrame(frameSlots(3'b100), -1);
        checkCount("postResetFifoLeft", 32'(wrPtr - rdPtr), 32'd0);

        // Run the counter up to 255, then one more frame wraps it to 0.
        guard = 0;
        while (expCount != 8'd255 && guard < 300) begin
            w = DBITS'($urandom());
            applyStimulus(w);
            checkFrame(frameSlots(w), -1);
            guard++;
        end
        checkCount("countAt255", 32'(word_count), 32'd255);
        applyStimulus(3'b010);
        checkFrame(frameSlots(3'b010), -1);
        checkCount("countWrapped", 32'(word_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
